// File: rtl/multiword_add_pkg.sv
// Shared definitions for the multiword nibble-serial adder.
package multiword_add_pkg;

   // Width of one adder slice in bits
   localparam int NIB_W = 4;

   // Largest legal WORDS value (operand width up to 64 bits)
   localparam int MAX_WORDS = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/multiword_add_ripple_carry_adder.sv
// 4-bit ripple-carry adder slice, reused once per nibble by the controller.
module ripple_carry_adder
   import multiword_add_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] sum,
   output logic             cout
);

   // Chain of full adders, carry rippling from bit 0 upward
   always_comb begin
      logic c;
      c   = cin;
      sum = '0;
      for (int i = 0; i < NIB_W; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      end
      cout = c;
   end

endmodule

// File: rtl/multiword_add_ctrl.sv
// Nibble-serial multiword adder controller. One operand pair is captured,
// then one nibble per cycle is pushed through a single 4-bit adder slice.
// Optional subtraction (a - b via inverted B and carry-in of 1) is enabled
// by defining MULTIWORD_ADD_SUB_EN, which also adds the 'sub' input port.
//
// state | meaning
// IDLE  | ready for an operand pair
// RUN   | one nibble added per cycle, idx walks 0..WORDS-1
// DONE  | result held until the consumer takes it
module multiword_add_ctrl
   import multiword_add_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NIB_W*WORDS-1:0]   a,
   input  logic [NIB_W*WORDS-1:0]   b,
   input  logic                     cin,
`ifdef MULTIWORD_ADD_SUB_EN
   input  logic                     sub,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NIB_W*WORDS-1:0]   sum,
   output logic                     cout,
   output logic                     busy
);

   localparam int W     = NIB_W * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   state_t           state;
   state_t           state_nx;
   logic [W-1:0]     a_reg;
   logic [W-1:0]     b_reg;
   logic [W-1:0]     sum_reg;
   logic             carry;
   logic             cout_reg;
   logic [IDX_W-1:0] idx;
   logic             sub_reg;
   logic             last;
   logic             accept;
   logic             sub_in;

   logic [NIB_W-1:0] slice_a;
   logic [NIB_W-1:0] slice_b;
   logic [NIB_W-1:0] slice_sum;
   logic             slice_cout;

`ifdef MULTIWORD_ADD_SUB_EN
   assign sub_in = sub;
`else
   assign sub_in = 1'b0;
`endif

   assign accept = (state == IDLE) && in_valid;
   assign last   = (idx == IDX_W'(WORDS - 1));

   // Current nibble of the captured operands; B is inverted when subtracting
   assign slice_a = a_reg[NIB_W*idx +: NIB_W];
   assign slice_b = b_reg[NIB_W*idx +: NIB_W] ^ {NIB_W{sub_reg}};

   ripple_carry_adder u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = RUN;
         RUN:     if (last)     state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture and per-nibble accumulation of the result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         sum_reg  <= '0;
         carry    <= 1'b0;
         cout_reg <= 1'b0;
         idx      <= '0;
         sub_reg  <= 1'b0;
      end else begin
         if (accept) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= sub_in;
            carry   <= sub_in ? 1'b1 : cin;
            idx     <= '0;
         end else if (state == RUN) begin
            sum_reg[NIB_W*idx +: NIB_W] <= slice_sum;
            carry                       <= slice_cout;
            idx                         <= idx + 1'b1;
            if (last) cout_reg <= slice_cout;
         end
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign sum       = sum_reg;
   assign cout      = cout_reg;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed and randomized check of multiword_add_ctrl with WORDS=4.
module tb_multiword_add_ctrl;

   localparam int WORDS = 4;
   localparam int W     = 4 * WORDS;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multiword_add_ctrl #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef MULTIWORD_ADD_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
      int           stall;
   } vec_t;

   vec_t vecs [12];
   int   n_vec;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One full transaction: accept, count latency, hold under back-pressure, consume
   task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tcin, input logic tsub, input logic [W-1:0] es,
                         input logic ec, input int stall);
      int lat;
      int waited;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      a = ta; b = tb_; cin = tcin; sub = tsub;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = ~ta; b = ~tb_; cin = ~tcin; sub = ~tsub;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         a = W'($urandom); b = W'($urandom);
      end
      check({name, " latency"}, 32'(lat), 32'(WORDS));
      check({name, " sum"}, {16'd0, sum}, {16'd0, es});
      check({name, " cout"}, {31'd0, cout}, {31'd0, ec});
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         @(negedge clk);
         a = W'($urandom); b = W'($urandom);
         check({name, " hold"}, {14'd0, out_valid, in_ready, sum},
                                {14'd0, 1'b1, 1'b0, es});
         check({name, " hold cout/busy"}, {30'd0, cout, busy}, {30'd0, ec, 1'b1});
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({name, " consumed"}, {29'd0, out_valid, in_ready, busy}, 32'b010);
   endtask

   initial begin
      logic [W:0] full;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b0;

      n_vec = 0;
      vecs[n_vec++] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 0};
      vecs[n_vec++] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1};
      vecs[n_vec++] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 3};
      vecs[n_vec++] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 0};
      vecs[n_vec++] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 0};
      vecs[n_vec++] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 2};
      vecs[n_vec++] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 0};
      vecs[n_vec++] = '{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1};
`ifdef MULTIWORD_ADD_SUB_EN
      vecs[n_vec++] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 0};
      vecs[n_vec++] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1};
`endif

      #12;
      check("reset outputs", {13'd0, in_ready, out_valid, busy, sum}, {13'd0, 3'b100, 16'h0000});
      check("reset cout", {31'd0, cout}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < n_vec; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].stall);

      // Reset in the middle of RUN aborts the operation
      @(negedge clk);
      in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrun reset", {13'd0, in_ready, out_valid, busy, sum}, {13'd0, 3'b100, 16'h0000});
      check("midrun reset cout", {31'd0, cout}, 32'd0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("reset no out_valid", {31'd0, out_valid}, 32'd0);
      end
      rst_n = 1'b1;
      run_op("after reset", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 0);

      // Random regression with back-pressure
      for (int n = 0; n < 10000; n++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rc;
         logic         rs;
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
`ifdef MULTIWORD_ADD_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         if (rs) full = {1'b0, ra} + {1'b0, ~rb} + 17'd1;
         else    full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
         run_op($sformatf("rnd%0d", n), ra, rb, rc, rs, full[W-1:0], full[W],
                int'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multiword_add_ctrl.md
MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 Parameter WORDS, default 4: number of 4-bit nibbles per operand, legal range 1..16; operand width W = 4*WORDS.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  W  operand A.
REQ-008 b  input  W  operand B.
REQ-009 cin  input  1  carry-in for nibble 0.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  W  result.
REQ-013 cout  output  1  carry out of the top nibble.
REQ-014 busy  output  1  high in RUN and DONE.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 IDLE: in_ready=1. On in_valid&in_ready, register a, b and cin, clear nibble index idx, and go to RUN.
REQ-017 RUN: each cycle, nibble idx of the registered A and B and the carry register SHALL drive a single 4-bit adder slice; the slice sum SHALL be written to sum[4*idx+3:4*idx]; the carry register SHALL take the slice carry; idx SHALL increment.
REQ-018 On the edge that processes idx==WORDS-1, the FSM SHALL go to DONE, set out_valid=1, and set cout to the final carry.
REQ-019 Latency: out_valid SHALL rise exactly WORDS clock edges after the accepting edge; for WORDS=1, the FSM SHALL go RUN->DONE after one edge.
REQ-020 DONE: sum, cout and out_valid SHALL hold stable while out_ready=0; on out_ready=1, out_valid SHALL clear and the FSM SHALL return to IDLE.
REQ-021 in_ready SHALL be 0 in RUN and DONE; a request SHALL NOT be accepted in the same cycle a result is consumed, giving a minimum of WORDS+2 cycles per operation.
REQ-022 Changes on a, b or cin while busy SHALL have no effect on the result in flight.
REQ-023 Arithmetic is unsigned modulo 2^W, and {cout,sum} SHALL equal a+b+cin exactly.
REQ-024 sum nibbles not yet processed in RUN SHALL retain their previous value; they are don't-care until out_valid.

Reset
REQ-025 Reset asserted SHALL immediately force IDLE, with in_ready=1, out_valid=0, busy=0, sum=0, cout=0, idx=0 and carry register=0.
REQ-026 Reset during RUN or DONE SHALL abort the operation without producing out_valid; the first request after reset release SHALL be processed normally.

Configuration
REQ-027 Macro MULTIWORD_ADD_SUB_EN SHALL control subtraction support.
REQ-028 With MULTIWORD_ADD_SUB_EN defined: an input port sub (1 bit) SHALL be captured with the operands; when sub=1, B nibbles SHALL be bit-inverted into the slice, the initial carry SHALL be 1, cin SHALL be ignored, and the result SHALL be a-b mod 2^W with cout=1 meaning no borrow.
REQ-029 Without MULTIWORD_ADD_SUB_EN: the sub port SHALL be absent and the block SHALL add only.

Structure
REQ-030 Shared package multiword_add_pkg SHALL hold the state enum (IDLE/RUN/DONE), constant NIB_W=4 and the maximum WORDS bound.
REQ-031 The block SHALL instantiate exactly one team 4-bit adder slice, sub-module ripple_carry_adder, reused every RUN cycle; all sequencing logic SHALL remain in multiword_add_ctrl.

Verification (WORDS=4)
REQ-032 a=0x00FF, b=0x0001, cin=0 -> out_valid 4 edges after accept, sum=0x0100, cout=0.
REQ-033 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; a=0x1234, b=0x1111, cin=1 -> sum=0x2346, cout=0.
REQ-034 Hold out_ready=0 for 3 cycles in DONE, toggling a and b -> sum and cout stable, in_ready=0; on out_ready=1, return to IDLE the next edge.
REQ-035 Assert rst_n=0 after 2 RUN edges -> all outputs at reset values, no out_valid; the next request 0x0003+0x0004 -> sum=0x0007.
REQ-036 With MULTIWORD_ADD_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
REQ-037 Random regression of 10k operations with random out_ready back-pressure -> every result matches a+b+cin and none is dropped or duplicated.
